// File: rtl/apb_demux_tmo.sv
// apb_demux_tmo: APB3/APB4 1-to-N_SLV demultiplexer with base/mask address map.
// One upstream APB master is routed to N_SLV downstream slaves with no added
// latency. An unmapped address gets an error response from an internal
// default slave. Slave pslverr is passed through. A mapped transfer that
// stalls in ACCESS for TIMEOUT_CYC cycles is aborted with an error response.
//
// Handshake: standard APB. Upstream SETUP is psel & !penable. ACCESS is
// psel & penable. The transfer completes in the cycle where pready is high.
// Downstream psel_o/penable_o follow the same rules for the selected slave.
// Unselected slaves always see psel_o = penable_o = 0.
//
// Ports:
//   pclk, preset             clock, asynchronous active-high reset
//   paddr, psel, penable,
//   pwrite, pwdata, pwstrb   upstream request
//   pready, prdata, pslverr  upstream response
//   paddr_o, pwrite_o,
//   pwdata_o, pwstrb_o       shared downstream request (pass-through)
//   psel_o, penable_o        per-slave select / enable
//   pready_i, prdata_i,
//   pslverr_i                per-slave response (prdata_i packed, slot i)
//   timeout_o                one-cycle pulse when a transfer is aborted by timeout
module apb_demux_tmo #(
    parameter int                      N_SLV       = 3,
    parameter int                      ADDR_W      = 32,
    parameter int                      DATA_W      = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE    = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK    = '0,
    parameter int                      TIMEOUT_CYC = 256,
    parameter int                      CNT_W       = 9,
    localparam int                     STRB_W      = DATA_W / 8
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [ADDR_W-1:0]       paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_W-1:0]       pwdata,
    input  logic [STRB_W-1:0]       pwstrb,
    output logic                    pready,
    output logic [DATA_W-1:0]       prdata,
    output logic                    pslverr,
    output logic [ADDR_W-1:0]       paddr_o,
    output logic                    pwrite_o,
    output logic [DATA_W-1:0]       pwdata_o,
    output logic [STRB_W-1:0]       pwstrb_o,
    output logic [N_SLV-1:0]        psel_o,
    output logic [N_SLV-1:0]        penable_o,
    input  logic [N_SLV-1:0]        pready_i,
    input  logic [N_SLV*DATA_W-1:0] prdata_i,
    input  logic [N_SLV-1:0]        pslverr_i,
    output logic                    timeout_o
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, dec_idx;
    logic               hit_q, hit_d, dec_hit;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [N_SLV-1:0]   dec_oh, sel_oh;
    logic               sel_rdy, sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               tmo_now;

    assign paddr_o  = paddr;
    assign pwrite_o = pwrite;
    assign pwdata_o = pwdata;
    assign pwstrb_o = pwstrb;

    // Address decode. Scanning from the top index down lets the lowest
    // matching index overwrite higher ones, so it wins on overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_oh  = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((paddr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                dec_hit    = 1'b1;
                dec_idx    = IDX_W'(i);
                dec_oh     = '0;
                dec_oh[i]  = 1'b1;
            end
        end
    end

    // Response mux for the slave latched at SETUP.
    always_comb begin
        sel_oh    = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_rdy   = pready_i[i];
                sel_err   = pslverr_i[i];
                sel_rdata = prdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmo_now = (TIMEOUT_CYC > 0) && (cnt == TMO_LAST);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= '0;
            idx_q <= '0;
            hit_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx_q <= idx_d;
            hit_q <= hit_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = idx_q;
        hit_d     = hit_q;
        psel_o    = '0;
        penable_o = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        timeout_o = 1'b0;

        case (state)
            IDLE: begin
                // Downstream SETUP in the same cycle as upstream SETUP.
                if (psel) begin
                    psel_o = dec_oh;
                end
                if (psel && !penable) begin
                    state_d = ACCESS;
                    idx_d   = dec_idx;
                    hit_d   = dec_hit;
                    cnt_d   = '0;
                end
            end

            ACCESS: begin
                if (!psel) begin
                    // Master abandoned the transfer: release the slave quietly.
                    state_d = IDLE;
                end else if (!hit_q) begin
                    // Default slave: immediate error, nothing selected downstream.
                    pready  = 1'b1;
                    pslverr = 1'b1;
                    state_d = IDLE;
                end else begin
                    psel_o    = sel_oh;
                    penable_o = penable ? sel_oh : '0;
                    if (sel_rdy) begin
                        // Slave response has priority over a coincident timeout.
                        pready  = 1'b1;
                        prdata  = sel_rdata;
                        pslverr = sel_err;
                        state_d = IDLE;
                    end else if (tmo_now) begin
                        pready    = 1'b1;
                        pslverr   = 1'b1;
                        timeout_o = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs go quiet the moment reset is applied, not at the next edge.
        if (preset) begin
            psel_o    = '0;
            penable_o = '0;
            pready    = 1'b0;
            prdata    = '0;
            pslverr   = 1'b0;
            timeout_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_demux_tmo.sv
// Directed bench for apb_demux_tmo. Inputs are driven 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
// The main instance uses a disjoint 4 KiB map with TIMEOUT_CYC = 4. A second
// instance shares all inputs and uses an overlapping map to exercise priority.
module tb_apb_demux_tmo;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    localparam logic [N*AW-1:0] BASE    = {32'h1000_2000, 32'h1000_1000, 32'h1000_0000};
    localparam logic [N*AW-1:0] MASK    = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
    localparam logic [N*AW-1:0] OV_BASE = {32'h2000_0000, 32'h1000_1000, 32'h1000_0000};
    localparam logic [N*AW-1:0] OV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000};

    logic          pclk;
    logic          preset;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pwstrb;
    logic [N-1:0]  pready_i, pslverr_i;
    logic [N*DW-1:0] prdata_i;

    logic          pready, pslverr, pwrite_o, timeout_o;
    logic [DW-1:0] prdata, pwdata_o;
    logic [AW-1:0] paddr_o;
    logic [SW-1:0] pwstrb_o;
    logic [N-1:0]  psel_o, penable_o;

    logic          ov_pready, ov_pslverr, ov_pwrite_o, ov_timeout_o;
    logic [DW-1:0] ov_prdata, ov_pwdata_o;
    logic [AW-1:0] ov_paddr_o;
    logic [SW-1:0] ov_pwstrb_o;
    logic [N-1:0]  ov_psel_o, ov_penable_o;

    // {psel_o, penable_o, pready, pslverr, timeout_o}
    logic [8:0] st;
    assign st = {psel_o, penable_o, pready, pslverr, timeout_o};

    int n_pass  = 0;
    int n_total = 0;

    apb_demux_tmo #(
        .N_SLV(N), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE(BASE), .SLV_MASK(MASK),
        .TIMEOUT_CYC(4), .CNT_W(9)
    ) dut (
        .pclk(pclk), .preset(preset),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pwstrb(pwstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pwstrb_o(pwstrb_o),
        .psel_o(psel_o), .penable_o(penable_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i),
        .timeout_o(timeout_o)
    );

    apb_demux_tmo #(
        .N_SLV(N), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE(OV_BASE), .SLV_MASK(OV_MASK),
        .TIMEOUT_CYC(4), .CNT_W(9)
    ) dut_ov (
        .pclk(pclk), .preset(preset),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pwstrb(pwstrb),
        .pready(ov_pready), .prdata(ov_prdata), .pslverr(ov_pslverr),
        .paddr_o(ov_paddr_o), .pwrite_o(ov_pwrite_o), .pwdata_o(ov_pwdata_o), .pwstrb_o(ov_pwstrb_o),
        .psel_o(ov_psel_o), .penable_o(ov_penable_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i),
        .timeout_o(ov_timeout_o)
    );

    // Clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Driver tasks
    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic sample();
        @(negedge pclk);
    endtask

    task automatic go_idle();
        next_cycle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pready_i = '0; pslverr_i = '0; prdata_i = '0;
    endtask

    // Tests
    task automatic test_reset();
        preset = 1'b1; paddr = 32'h1000_1004; psel = 1'b1; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pwstrb = '0;
        pready_i = 3'b111; pslverr_i = 3'b111; prdata_i = {3{32'hFFFF_FFFF}};
        #2;
        n_total++;
        if (st !== 9'b000_000_000) $display("FAIL reset_ctrl got %b exp %b", st, 9'b000_000_000);
        else n_pass++;
        n_total++;
        if (prdata !== 32'h0) $display("FAIL reset_prdata got %h exp %h", prdata, 32'h0);
        else n_pass++;
        next_cycle();
        next_cycle();
        preset = 1'b0;
        psel = 1'b0; pready_i = '0; pslverr_i = '0; prdata_i = '0;
    endtask

    task automatic test_write_wait();
        next_cycle();
        paddr = 32'h1000_1004; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        pwdata = 32'hA5A5_0001; pwstrb = 4'b0110;
        prdata_i = {32'h0, 32'h5555_1111, 32'h0}; pslverr_i = 3'b010;
        sample();
        n_total++;
        if (st !== 9'b010_000_000) $display("FAIL wr_setup got %b exp %b", st, 9'b010_000_000);
        else n_pass++;
        n_total++;
        if ({paddr_o, pwrite_o, pwdata_o, pwstrb_o} !== {32'h1000_1004, 1'b1, 32'hA5A5_0001, 4'b0110})
            $display("FAIL wr_passthru got %h %b %h %b exp 10001004 1 a5a50001 0110",
                     paddr_o, pwrite_o, pwdata_o, pwstrb_o);
        else n_pass++;
        next_cycle();
        penable = 1'b1;
        sample();
        n_total++;
        if ({st, prdata} !== {9'b010_010_000, 32'h0})
            $display("FAIL wr_wait1 got %b %h exp %b %h", st, prdata, 9'b010_010_000, 32'h0);
        else n_pass++;
        // Address change during ACCESS must not move the selection.
        next_cycle();
        paddr = 32'h1000_2000;
        sample();
        n_total++;
        if (st !== 9'b010_010_000) $display("FAIL wr_wait2 got %b exp %b", st, 9'b010_010_000);
        else n_pass++;
        next_cycle();
        pready_i = 3'b010; pslverr_i = 3'b000;
        sample();
        n_total++;
        if (st !== 9'b010_010_100) $display("FAIL wr_done got %b exp %b", st, 9'b010_010_100);
        else n_pass++;
        go_idle();
        sample();
        n_total++;
        if (st !== 9'b000_000_000) $display("FAIL wr_idle got %b exp %b", st, 9'b000_000_000);
        else n_pass++;
    endtask

    task automatic test_read_err();
        next_cycle();
        paddr = 32'h1000_2010; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        prdata_i = {32'hDEAD_BEEF, 32'h0, 32'h0}; pslverr_i = 3'b100;
        sample();
        n_total++;
        if (st !== 9'b100_000_000) $display("FAIL rd_setup got %b exp %b", st, 9'b100_000_000);
        else n_pass++;
        next_cycle();
        penable = 1'b1; pready_i = 3'b100;
        sample();
        n_total++;
        if (st !== 9'b100_100_110) $display("FAIL rd_done got %b exp %b", st, 9'b100_100_110);
        else n_pass++;
        n_total++;
        if (prdata !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h exp %h", prdata, 32'hDEAD_BEEF);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_miss();
        next_cycle();
        paddr = 32'h2000_0000; psel = 1'b1; penable = 1'b0;
        pready_i = 3'b111; prdata_i = {3{32'hFFFF_FFFF}};
        sample();
        n_total++;
        if (st !== 9'b000_000_000) $display("FAIL miss_setup got %b exp %b", st, 9'b000_000_000);
        else n_pass++;
        next_cycle();
        penable = 1'b1;
        sample();
        n_total++;
        if (st !== 9'b000_000_110) $display("FAIL miss_resp got %b exp %b", st, 9'b000_000_110);
        else n_pass++;
        n_total++;
        if (prdata !== 32'h0) $display("FAIL miss_data got %h exp %h", prdata, 32'h0);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_timeout_back_to_back();
        next_cycle();
        paddr = 32'h1000_0000; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        prdata_i = {32'h0, 32'h0, 32'h7777_7777};
        sample();
        n_total++;
        if (st !== 9'b001_000_000) $display("FAIL tmo_setup got %b exp %b", st, 9'b001_000_000);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            penable = 1'b1;
            sample();
            n_total++;
            if (st !== 9'b001_001_000) $display("FAIL tmo_wait%0d got %b exp %b", k, st, 9'b001_001_000);
            else n_pass++;
        end
        next_cycle();
        sample();
        n_total++;
        if ({st, prdata} !== {9'b001_001_111, 32'h0})
            $display("FAIL tmo_abort got %b %h exp %b %h", st, prdata, 9'b001_001_111, 32'h0);
        else n_pass++;
        // New SETUP immediately after the abort.
        next_cycle();
        paddr = 32'h1000_2000; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        sample();
        n_total++;
        if (st !== 9'b100_000_000) $display("FAIL b2b_setup got %b exp %b", st, 9'b100_000_000);
        else n_pass++;
        next_cycle();
        penable = 1'b1; pready_i = 3'b100; prdata_i = {32'h1234_5678, 32'h0, 32'h0};
        sample();
        n_total++;
        if ({st, prdata} !== {9'b100_100_100, 32'h1234_5678})
            $display("FAIL b2b_done got %b %h exp %b %h", st, prdata, 9'b100_100_100, 32'h1234_5678);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_psel_drop();
        logic any_pulse;
        next_cycle();
        paddr = 32'h1000_0000; psel = 1'b1; penable = 1'b0;
        next_cycle();
        penable = 1'b1;
        sample();
        n_total++;
        if (st !== 9'b001_001_000) $display("FAIL drop_access got %b exp %b", st, 9'b001_001_000);
        else n_pass++;
        next_cycle();
        psel = 1'b0; penable = 1'b0;
        any_pulse = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            any_pulse = any_pulse | (|st);
            next_cycle();
        end
        n_total++;
        if (any_pulse !== 1'b0) $display("FAIL drop_quiet got %b exp %b", any_pulse, 1'b0);
        else n_pass++;
        paddr = 32'h1000_1000; psel = 1'b1; penable = 1'b0;
        sample();
        n_total++;
        if (st !== 9'b010_000_000) $display("FAIL drop_resetup got %b exp %b", st, 9'b010_000_000);
        else n_pass++;
        next_cycle();
        penable = 1'b1; pready_i = 3'b010;
        sample();
        n_total++;
        if (st !== 9'b010_010_100) $display("FAIL drop_redone got %b exp %b", st, 9'b010_010_100);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_overlap();
        next_cycle();
        paddr = 32'h1000_1004; psel = 1'b1; penable = 1'b0;
        sample();
        n_total++;
        if ({ov_psel_o, psel_o} !== {3'b001, 3'b010})
            $display("FAIL ovl_select got %b %b exp 001 010", ov_psel_o, psel_o);
        else n_pass++;
        next_cycle();
        penable = 1'b1; pready_i = 3'b011;
        prdata_i = {32'h0, 32'h0000_00B1, 32'h0000_00A0};
        sample();
        n_total++;
        if ({ov_pready, ov_prdata} !== {1'b1, 32'h0000_00A0})
            $display("FAIL ovl_data got %b %h exp 1 000000a0", ov_pready, ov_prdata);
        else n_pass++;
        n_total++;
        if ({pready, prdata} !== {1'b1, 32'h0000_00B1})
            $display("FAIL ovl_ref_data got %b %h exp 1 000000b1", pready, prdata);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        paddr = 32'h1000_1004; psel = 1'b1; penable = 1'b0;
        next_cycle();
        penable = 1'b1;
        sample();
        n_total++;
        if (st !== 9'b010_010_000) $display("FAIL rstm_access got %b exp %b", st, 9'b010_010_000);
        else n_pass++;
        next_cycle();
        pready_i = 3'b010; prdata_i = {32'h0, 32'hCAFE_0001, 32'h0};
        preset = 1'b1;
        #1;
        n_total++;
        if ({st, prdata} !== {9'b000_000_000, 32'h0})
            $display("FAIL rstm_abort got %b %h exp %b %h", st, prdata, 9'b000_000_000, 32'h0);
        else n_pass++;
        next_cycle();
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pready_i = '0; prdata_i = '0;
        sample();
        n_total++;
        if (st !== 9'b000_000_000) $display("FAIL rstm_release got %b exp %b", st, 9'b000_000_000);
        else n_pass++;
        // A fresh unmapped transfer must see the normal two-cycle error.
        next_cycle();
        paddr = 32'h2000_0000; psel = 1'b1; penable = 1'b0;
        next_cycle();
        penable = 1'b1;
        sample();
        n_total++;
        if (st !== 9'b000_000_110) $display("FAIL rstm_after got %b exp %b", st, 9'b000_000_110);
        else n_pass++;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_write_wait();
        test_read_err();
        test_miss();
        test_timeout_back_to_back();
        test_psel_drop();
        test_overlap();
        test_reset_mid();
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
